// File: rtl/msk_lbox_pkg.sv
// Shared constants and FSM encoding for the iterative masked Clyde lbox.
// Rotation amounts are in unmasked bit positions; callers scale them by the share count.
package msk_lbox_pkg;

    localparam int N_LAYERS = 6;

    localparam int FWD_R1  = 12;
    localparam int FWD_R2  = 3;
    localparam int FWD_R3  = 17;
    localparam int FWD_R4  = 31;
    localparam int FWD_R5A = 26;
    localparam int FWD_R5B = 25;
    localparam int FWD_R6  = 15;

    localparam int INV_R1   = 25;
    localparam int INV_R2   = 31;
    localparam int INV_R3   = 20;
    localparam int INV_R4   = 31;
    localparam int INV_R5A  = 26;
    localparam int INV_R5B  = 25;
    localparam int INV_R6   = 17;
    localparam int INV_ROUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lbox_state_e;

    // Layers per cycle must divide the layer count so the counter lands exactly on N_LAYERS.
    function automatic bit lpc_legal(input int lpc);
        return (lpc == 1) || (lpc == 2) || (lpc == 3) || (lpc == 6);
    endfunction

endpackage

// File: rtl/msk_lbox_layer.sv
// One combinational XOR layer of the masked lbox; R0..R3 hold (x|c, y|d, a, b).
// All operations are share-wise, so a rotation by r moves r whole D-bit share groups.
module msk_lbox_layer
    import msk_lbox_pkg::*;
#(
    parameter int D = 2
) (
    input  logic [2:0]      i_layer,
    input  logic            i_inverse,
    input  logic [32*D-1:0] i_r0,
    input  logic [32*D-1:0] i_r1,
    input  logic [32*D-1:0] i_r2,
    input  logic [32*D-1:0] i_r3,
    output logic [32*D-1:0] o_r0,
    output logic [32*D-1:0] o_r1,
    output logic [32*D-1:0] o_r2,
    output logic [32*D-1:0] o_r3
);

    function automatic logic [32*D-1:0] ror(input logic [32*D-1:0] v, input int r);
        return (v >> (r * D)) | (v << ((32 - r) * D));
    endfunction

    always_comb begin
        o_r0 = i_r0;
        o_r1 = i_r1;
        o_r2 = i_r2;
        o_r3 = i_r3;
        if (!i_inverse) begin
            case (i_layer)
                3'd1: begin
                    o_r2 = i_r0 ^ ror(i_r0, FWD_R1);
                    o_r3 = i_r1 ^ ror(i_r1, FWD_R1);
                end
                3'd2: begin
                    o_r2 = i_r2 ^ ror(i_r2, FWD_R2);
                    o_r3 = i_r3 ^ ror(i_r3, FWD_R2);
                end
                3'd3: begin
                    o_r2 = i_r2 ^ ror(i_r0, FWD_R3);
                    o_r3 = i_r3 ^ ror(i_r1, FWD_R3);
                end
                // x and y are dead from here on, so c/d overwrite them
                3'd4: begin
                    o_r0 = i_r2 ^ ror(i_r2, FWD_R4);
                    o_r1 = i_r3 ^ ror(i_r3, FWD_R4);
                end
                3'd5: begin
                    o_r2 = i_r2 ^ ror(i_r1, FWD_R5A);
                    o_r3 = i_r3 ^ ror(i_r0, FWD_R5B);
                end
                3'd6: begin
                    o_r2 = i_r2 ^ ror(i_r0, FWD_R6);
                    o_r3 = i_r3 ^ ror(i_r1, FWD_R6);
                end
                default: ;
            endcase
        end else begin
            case (i_layer)
                3'd1: begin
                    o_r2 = i_r0 ^ ror(i_r0, INV_R1);
                    o_r3 = i_r1 ^ ror(i_r1, INV_R1);
                end
                3'd2: begin
                    o_r0 = i_r0 ^ ror(i_r2, INV_R2);
                    o_r1 = i_r1 ^ ror(i_r3, INV_R2);
                end
                3'd3: begin
                    o_r0 = i_r0 ^ ror(i_r2, INV_R3);
                    o_r1 = i_r1 ^ ror(i_r3, INV_R3);
                end
                3'd4: begin
                    o_r2 = i_r0 ^ ror(i_r0, INV_R4);
                    o_r3 = i_r1 ^ ror(i_r1, INV_R4);
                end
                3'd5: begin
                    o_r0 = i_r0 ^ ror(i_r3, INV_R5A);
                    o_r1 = i_r1 ^ ror(i_r2, INV_R5B);
                end
                3'd6: begin
                    o_r2 = i_r2 ^ ror(i_r0, INV_R6);
                    o_r3 = i_r3 ^ ror(i_r1, INV_R6);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/msk_lbox_seq.sv
// Iterative masked Clyde lbox (forward/inverse) with valid/ready on both sides.
// Optional MSKLBOX_SEQ_CLEAR_EN zeroes state on result hand-off and gates a/b while idle.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | in_ready=1, waiting for an operand
// ST_BUSY | applying LPC layers per clock until the layer count hits 6
// ST_DONE | out_valid=1, a/b held until out_ready
module msk_lbox_seq
    import msk_lbox_pkg::*;
#(
    parameter int d   = 2,
    parameter int LPC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            inverse,
    input  logic [32*d-1:0] x,
    input  logic [32*d-1:0] y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [32*d-1:0] a,
    output logic [32*d-1:0] b
);

    if (!lpc_legal(LPC)) begin : g_bad_lpc
        $error("msk_lbox_seq: LPC=%0d is not one of 1, 2, 3, 6", LPC);
    end

    function automatic logic [32*d-1:0] ror(input logic [32*d-1:0] v, input int r);
        return (v >> (r * d)) | (v << ((32 - r) * d));
    endfunction

    lbox_state_e             r_state;
    lbox_state_e             w_state_nxt;
    logic [2:0]              r_count;
    logic [2:0]              w_count_nxt;
    logic                    w_last;
    logic                    r_inverse;
    logic [32*d-1:0]         r_r0;
    logic [32*d-1:0]         r_r1;
    logic [32*d-1:0]         r_r2;
    logic [32*d-1:0]         r_r3;
    logic [LPC:0][32*d-1:0]  w_r0;
    logic [LPC:0][32*d-1:0]  w_r1;
    logic [LPC:0][32*d-1:0]  w_r2;
    logic [LPC:0][32*d-1:0]  w_r3;
    logic [32*d-1:0]         w_a_rot;
    logic [32*d-1:0]         w_b_rot;

    assign w_count_nxt = r_count + 3'(LPC);
    assign w_last      = (w_count_nxt == 3'(N_LAYERS));

    assign w_r0[0] = r_r0;
    assign w_r1[0] = r_r1;
    assign w_r2[0] = r_r2;
    assign w_r3[0] = r_r3;

    for (genvar k = 0; k < LPC; k++) begin : g_layer
        logic [2:0] w_idx;
        assign w_idx = r_count + 3'(k + 1);

        msk_lbox_layer #(
            .D (d)
        ) u_layer (
            .i_layer   (w_idx),
            .i_inverse (r_inverse),
            .i_r0      (w_r0[k]),
            .i_r1      (w_r1[k]),
            .i_r2      (w_r2[k]),
            .i_r3      (w_r3[k]),
            .o_r0      (w_r0[k+1]),
            .o_r1      (w_r1[k+1]),
            .o_r2      (w_r2[k+1]),
            .o_r3      (w_r3[k+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            // No same-cycle re-accept: a new operand is only taken back in IDLE.
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_r0      <= '0;
            r_r1      <= '0;
            r_r2      <= '0;
            r_r3      <= '0;
            r_count   <= '0;
            r_inverse <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_r0      <= x;
                        r_r1      <= y;
                        r_count   <= '0;
                        r_inverse <= inverse;
                    end
                end
                ST_BUSY: begin
                    r_r0    <= w_r0[LPC];
                    r_r1    <= w_r1[LPC];
                    r_r2    <= w_r2[LPC];
                    r_r3    <= w_r3[LPC];
                    r_count <= w_count_nxt;
                end
                ST_DONE: begin
`ifdef MSKLBOX_SEQ_CLEAR_EN
                    if (out_ready) begin
                        r_r0 <= '0;
                        r_r1 <= '0;
                        r_r2 <= '0;
                        r_r3 <= '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // The inverse's closing rotation costs only wiring, so it stays on the output.
    always_comb begin
        w_a_rot = r_inverse ? ror(r_r2, INV_ROUT) : r_r2;
        w_b_rot = r_inverse ? ror(r_r3, INV_ROUT) : r_r3;
`ifdef MSKLBOX_SEQ_CLEAR_EN
        a = out_valid ? w_a_rot : '0;
        b = out_valid ? w_b_rot : '0;
`else
        a = w_a_rot;
        b = w_b_rot;
`endif
    end

endmodule

// File: tb/tb_msk_lbox_seq.sv
// Self-checking bench for msk_lbox_seq: directed table, share-wise, LPC, backpressure, reset.
`timescale 1ns/1ps
module tb_msk_lbox_seq;

    typedef struct {
        logic        inv;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    logic clk;
    logic rst_n;

    logic        iv0, ir0, inv0, ov0, or0;
    logic [63:0] x0, y0, a0, b0;
    logic        iv1, ir1, inv1, ov1, or1;
    logic [63:0] x1, y1, a1, b1;
    logic        iv2, ir2, inv2, ov2, or2;
    logic [95:0] x2, y2, a2, b2;

    int n_pass = 0;
    int n_tot  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    msk_lbox_seq #(.d(2), .LPC(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .inverse(inv0),
        .x(x0), .y(y0), .out_valid(ov0), .out_ready(or0), .a(a0), .b(b0));

    msk_lbox_seq #(.d(2), .LPC(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .inverse(inv1),
        .x(x1), .y(y1), .out_valid(ov1), .out_ready(or1), .a(a1), .b(b1));

    msk_lbox_seq #(.d(3), .LPC(6)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .inverse(inv2),
        .x(x2), .y(y2), .out_valid(ov2), .out_ready(or2), .a(a2), .b(b2));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] v, input int r);
        return (v >> r) | (v << (32 - r));
    endfunction

    // Reference lbox, written as the plain two-word algorithm.
    function automatic logic [63:0] lbox(input logic inv, input logic [31:0] xi, input logic [31:0] yi);
        logic [31:0] xx, yy, aa, bb, cc, dd;
        xx = xi; yy = yi;
        if (!inv) begin
            cc = xx ^ ror32(xx, 12); dd = yy ^ ror32(yy, 12);
            cc ^= ror32(cc, 3);      dd ^= ror32(dd, 3);
            xx = cc ^ ror32(xx, 17); yy = dd ^ ror32(yy, 17);
            cc = xx ^ ror32(xx, 31); dd = yy ^ ror32(yy, 31);
            xx ^= ror32(dd, 26);     yy ^= ror32(cc, 25);
            xx ^= ror32(cc, 15);     yy ^= ror32(dd, 15);
            return {xx, yy};
        end
        aa = xx ^ ror32(xx, 25); bb = yy ^ ror32(yy, 25);
        cc = xx ^ ror32(aa, 31); dd = yy ^ ror32(bb, 31);
        cc ^= ror32(aa, 20);     dd ^= ror32(bb, 20);
        aa = cc ^ ror32(cc, 31); bb = dd ^ ror32(dd, 31);
        cc ^= ror32(bb, 26);     dd ^= ror32(aa, 25);
        aa ^= ror32(cc, 17);     bb ^= ror32(dd, 17);
        return {ror32(aa, 16), ror32(bb, 16)};
    endfunction

    function automatic logic [63:0] pack2(input logic [31:0] v, input logic [31:0] m);
        logic [63:0] s;
        for (int i = 0; i < 32; i++) begin
            s[2*i]   = v[i] ^ m[i];
            s[2*i+1] = m[i];
        end
        return s;
    endfunction

    function automatic logic [95:0] pack3(input logic [31:0] v, input logic [31:0] m1, input logic [31:0] m2);
        logic [95:0] s;
        for (int i = 0; i < 32; i++) begin
            s[3*i]   = v[i] ^ m1[i] ^ m2[i];
            s[3*i+1] = m1[i];
            s[3*i+2] = m2[i];
        end
        return s;
    endfunction

    function automatic logic [31:0] unm2(input logic [63:0] s);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = s[2*i] ^ s[2*i+1];
        return r;
    endfunction

    function automatic logic [31:0] sh3(input logic [95:0] s, input int j);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = s[3*i+j];
        return r;
    endfunction

    function automatic logic ir_of(input int sel);
        case (sel)
            0: return ir0;
            1: return ir1;
            default: return ir2;
        endcase
    endfunction

    function automatic logic ov_of(input int sel);
        case (sel)
            0: return ov0;
            1: return ov1;
            default: return ov2;
        endcase
    endfunction

    // Issue one operand on DUT sel, measure latency in clocks, optionally take the result.
    task automatic run_op(input int sel, input logic inv, input logic [31:0] xv, input logic [31:0] yv,
                          input bit rnd_mask, input bit take,
                          output logic [31:0] ra, output logic [31:0] rb,
                          output logic [95:0] sa, output logic [95:0] sb, output int lat);
        logic [31:0] m1x, m2x, m1y, m2y;
        logic ov;
        m1x = rnd_mask ? $urandom : 32'h0;
        m2x = rnd_mask ? $urandom : 32'h0;
        m1y = rnd_mask ? $urandom : 32'h0;
        m2y = rnd_mask ? $urandom : 32'h0;
        @(negedge clk);
        case (sel)
            0: begin iv0 = 1'b1; inv0 = inv; x0 = pack2(xv, m1x); y0 = pack2(yv, m1y); end
            1: begin iv1 = 1'b1; inv1 = inv; x1 = pack2(xv, m1x); y1 = pack2(yv, m1y); end
            default: begin iv2 = 1'b1; inv2 = inv; x2 = pack3(xv, m1x, m2x); y2 = pack3(yv, m1y, m2y); end
        endcase
        chk($sformatf("dut%0d in_ready at issue", sel), 64'(ir_of(sel)), 64'd1);
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        // Scramble inputs after acceptance: the unit must have latched them.
        case (sel)
            0: begin iv0 = 1'b0; inv0 = ~inv; x0 = {$urandom, $urandom}; y0 = {$urandom, $urandom}; end
            1: begin iv1 = 1'b0; inv1 = ~inv; x1 = {$urandom, $urandom}; y1 = {$urandom, $urandom}; end
            default: begin iv2 = 1'b0; inv2 = ~inv; x2 = {$urandom, $urandom, $urandom}; y2 = {$urandom, $urandom, $urandom}; end
        endcase
        chk($sformatf("dut%0d in_ready while busy", sel), 64'(ir_of(sel)), 64'd0);
        ov = ov_of(sel);
        while (!ov && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            ov = ov_of(sel);
        end
        chk($sformatf("dut%0d out_valid seen", sel), 64'(ov), 64'd1);
        case (sel)
            0: begin ra = unm2(a0); rb = unm2(b0); sa = {32'h0, a0}; sb = {32'h0, b0}; end
            1: begin ra = unm2(a1); rb = unm2(b1); sa = {32'h0, a1}; sb = {32'h0, b1}; end
            default: begin
                ra = sh3(a2, 0) ^ sh3(a2, 1) ^ sh3(a2, 2);
                rb = sh3(b2, 0) ^ sh3(b2, 1) ^ sh3(b2, 2);
                sa = a2; sb = b2;
            end
        endcase
        if (take) begin
            case (sel)
                0: or0 = 1'b1;
                1: or1 = 1'b1;
                default: or2 = 1'b1;
            endcase
            @(posedge clk);
            @(negedge clk);
            or0 = 1'b0; or1 = 1'b0; or2 = 1'b0;
            chk($sformatf("dut%0d idle after take", sel), {62'd0, ir_of(sel), ov_of(sel)}, 64'h2);
        end
    endtask

    initial begin
        vec_t        tbl [8];
        logic [63:0] w;
        logic [31:0] ra, rb, xv, yv;
        logic [95:0] sa, sb;
        logic [63:0] hold_a, hold_b;
        logic        inv, seen;
        int          lat;
        int          exp_lat [3];

        exp_lat[0] = 6; exp_lat[1] = 2; exp_lat[2] = 1;
        rst_n = 1'b0;
        iv0 = 0; inv0 = 0; or0 = 0; x0 = '0; y0 = '0;
        iv1 = 0; inv1 = 0; or1 = 0; x1 = '0; y1 = '0;
        iv2 = 0; inv2 = 0; or2 = 0; x2 = '0; y2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready/out_valid", {62'd0, ir0, ov0}, 64'h2);
        chk("reset a", a0, 64'h0);
        chk("reset b", b0, 64'h0);
        chk("reset dut1/dut2 ready", {62'd0, ir1, ir2}, 64'h3);
        rst_n = 1'b1;

        tbl[0] = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[1] = '{1'b0, 32'h00000001, 32'h0, 32'h2014406E, 32'h1BC001B0};
        tbl[2] = '{1'b1, 32'h2014406E, 32'h1BC001B0, 32'h00000001, 32'h0};
        w = lbox(1'b0, 32'h12345678, 32'h9ABCDEF0);
        tbl[3] = '{1'b0, 32'h12345678, 32'h9ABCDEF0, w[63:32], w[31:0]};
        tbl[4] = '{1'b1, w[63:32], w[31:0], 32'h12345678, 32'h9ABCDEF0};
        tbl[5] = '{1'b0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0};
        tbl[6] = '{1'b1, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF};
        w = lbox(1'b1, 32'hDEADBEEF, 32'h0BADF00D);
        tbl[7] = '{1'b1, 32'hDEADBEEF, 32'h0BADF00D, w[63:32], w[31:0]};

        foreach (tbl[i]) begin
            run_op(0, tbl[i].inv, tbl[i].x, tbl[i].y, 1'b1, 1'b1, ra, rb, sa, sb, lat);
            chk($sformatf("vec%0d a", i), 64'(ra), 64'(tbl[i].ea));
            chk($sformatf("vec%0d b", i), 64'(rb), 64'(tbl[i].eb));
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'd6);
        end

        // d=3 share-wise: only share 0 carries data, so shares 1 and 2 must stay zero.
        run_op(2, 1'b0, 32'h00000001, 32'h0, 1'b0, 1'b1, ra, rb, sa, sb, lat);
        chk("d3 a shares 1/2", {sh3(sa, 1), sh3(sa, 2)}, 64'h0);
        chk("d3 b shares 1/2", {sh3(sb, 1), sh3(sb, 2)}, 64'h0);
        chk("d3 a share 0", 64'(sh3(sa, 0)), 64'h2014406E);
        chk("d3 b share 0", 64'(sh3(sb, 0)), 64'h1BC001B0);
        chk("d3 lpc6 latency", 64'(lat), 64'd1);

        for (int n = 0; n < 120; n++) begin
            xv  = $urandom;
            yv  = $urandom;
            inv = 1'($urandom_range(0, 1));
            w   = lbox(inv, xv, yv);
            for (int s = 0; s < 3; s++) begin
                run_op(s, inv, xv, yv, 1'b1, 1'b1, ra, rb, sa, sb, lat);
                chk($sformatf("rand%0d dut%0d inv=%0d result", n, s, inv), {ra, rb}, w);
                chk($sformatf("rand%0d dut%0d latency", n, s), 64'(lat), 64'(exp_lat[s]));
            end
        end

        // Backpressure: hold the result 20 cycles while a stray in_valid is presented.
        xv = 32'hCAFEF00D; yv = 32'h01234567;
        run_op(0, 1'b1, xv, yv, 1'b1, 1'b0, ra, rb, sa, sb, lat);
        chk("bp result", {ra, rb}, lbox(1'b1, xv, yv));
        hold_a = a0; hold_b = b0;
        for (int c = 0; c < 20; c++) begin
            iv0 = 1'b1; inv0 = 1'($urandom_range(0, 1));
            x0 = {$urandom, $urandom}; y0 = {$urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp hold cycle %0d", c),
                {60'd0, (a0 === hold_a), (b0 === hold_b), ir0, ov0}, 64'hD);
        end
        iv0 = 1'b0; or0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or0 = 1'b0;
        chk("bp idle after take", {62'd0, ir0, ov0}, 64'h2);
`ifdef MSKLBOX_SEQ_CLEAR_EN
        chk("bp cleared a", a0, 64'h0);
        chk("bp cleared b", b0, 64'h0);
`endif
        xv = 32'h55AA33CC; yv = 32'h0F0F0F0F;
        run_op(0, 1'b0, xv, yv, 1'b1, 1'b1, ra, rb, sa, sb, lat);
        chk("post-bp result", {ra, rb}, lbox(1'b0, xv, yv));
        chk("post-bp latency", 64'(lat), 64'd6);

        // Reset while BUSY with two layers done; no result may follow.
        @(negedge clk);
        iv0 = 1'b1; inv0 = 1'b1; x0 = {$urandom, $urandom}; y0 = {$urandom, $urandom};
        @(posedge clk);
        @(negedge clk);
        iv0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midop reset ready/valid", {62'd0, ir0, ov0}, 64'h2);
        chk("midop reset a", a0, 64'h0);
        chk("midop reset b", b0, 64'h0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | ov0;
        end
        chk("no result after reset", 64'(seen), 64'd0);
        xv = 32'h89ABCDEF; yv = 32'hFEDCBA98;
        run_op(0, 1'b1, xv, yv, 1'b1, 1'b1, ra, rb, sa, sb, lat);
        chk("post-reset result", {ra, rb}, lbox(1'b1, xv, yv));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, %0d/%0d so far", n_pass, n_tot);
        $fatal(1, "timeout");
    end

endmodule
